timer_datapath: RTL and testbench

Datapath companion to the timer control FSM. It shares that FSM's clock and consumes its `shift_ena` and `counting` strobes. During the shift phase it captures a serial delay value MSB-first. During the counting phase it counts down (delay+1)×CYCLES_PER_UNIT cycles. It returns `done_counting` to the FSM and presents the remaining delay units on `count`.

---
 rtl/timer_datapath.sv | 53 +++++
 tb/tb_timer_datapath.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_datapath.sv
// timer_datapath: captures a serial delay MSB-first, then counts down (delay+1)*CYCLES_PER_UNIT cycles
module timer_datapath #(
    parameter int WIDTH           = 4,
    parameter int CYCLES_PER_UNIT = 1000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             data,
    input  logic             shift_ena,
    input  logic             counting,
    output logic [WIDTH-1:0] count,
    output logic             done_counting
);
    localparam int SW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [SW-1:0] SUB_MAX = SW'(CYCLES_PER_UNIT - 1);

    logic [WIDTH-1:0] delay_q, delay_d;
    logic [SW-1:0]    sub_q, sub_d;
    logic             delay_zero, sub_zero;

    assign delay_zero = (delay_q == '0);
    assign sub_zero   = (sub_q == '0);

    // Shift wins over counting; a fully drained counter saturates instead of wrapping
    always_comb begin
        delay_d = delay_q;
        sub_d   = sub_q;
        if (shift_ena) begin
            delay_d = WIDTH'({delay_q, data});
            sub_d   = SUB_MAX;
        end else if (counting) begin
            if (!sub_zero) begin
                sub_d = sub_q - SW'(1);
            end else if (!delay_zero) begin
                delay_d = delay_q - WIDTH'(1);
                sub_d   = SUB_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            delay_q <= '0;
            sub_q   <= SUB_MAX;
        end else begin
            delay_q <= delay_d;
            sub_q   <= sub_d;
        end
    end

    assign count         = delay_q;
    assign done_counting = counting & delay_zero & sub_zero;
endmodule

// File: tb/tb_timer_datapath.sv
// tb_timer_datapath: scoreboard bench for timer_datapath at CYCLES_PER_UNIT=1000 and CYCLES_PER_UNIT=1
module tb_timer_datapath;
    typedef struct packed {
        logic [3:0] cnt;
        logic       dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       data = 1'b0;
    logic       shift_ena = 1'b0;
    logic       counting = 1'b0;
    logic [3:0] count1, count2;
    logic       done1, done2;
    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    timer_datapath #(.WIDTH(4), .CYCLES_PER_UNIT(1000)) dut1 (
        .clk(clk), .resetn(resetn), .data(data), .shift_ena(shift_ena),
        .counting(counting), .count(count1), .done_counting(done1)
    );

    timer_datapath #(.WIDTH(4), .CYCLES_PER_UNIT(1)) dut2 (
        .clk(clk), .resetn(resetn), .data(data), .shift_ena(shift_ena),
        .counting(counting), .count(count2), .done_counting(done2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic sh, input logic cn, input logic d);
        shift_ena = sh;
        counting  = cn;
        data      = d;
    endtask

    task automatic load(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            set(1'b1, 1'b0, v[i]);
            step();
        end
        set(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        exp_t e;
        #3;
        exp_q.push_back({4'd0, 1'b0});
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL reset_initial: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        step();
        resetn = 1'b1;
        load(4'hA);
        for (int n = 0; n < 20; n++) begin
            set(1'b0, 1'b1, 1'b0);
            step();
        end
        exp_q.push_back({4'hA, 1'b0});
        #2;
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL reset_precount: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        resetn = 1'b0;
        exp_q.push_back({4'd0, 1'b0});
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL reset_async: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        step();
        exp_q.push_back({4'd0, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL reset_held: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        step();
        resetn = 1'b1;
        set(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_shift();
        exp_t e;
        logic [3:0] word = 4'b1101;
        logic [3:0] acc = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            set(1'b1, 1'b0, word[i]);
            exp_q.push_back({acc, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({count1, done1} !== {e.cnt, e.dn}) begin
                n_fail++;
                $display("FAIL shift_bit%0d: count=%0d done=%0b expected count=%0d done=%0b", i, count1, done1, e.cnt, e.dn);
            end
            acc = {acc[2:0], word[i]};
            step();
        end
        set(1'b0, 1'b0, 1'b0);
        exp_q.push_back({4'd13, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL shift_final: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        step();
    endtask

    task automatic test_countdown();
        exp_t e;
        load(4'd2);
        for (int n = 1; n <= 3000; n++) begin
            set(1'b0, 1'b1, 1'b0);
            exp_q.push_back({4'(2 - (n - 1) / 1000), n == 3000});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({count1, done1} !== {e.cnt, e.dn}) begin
                n_fail++;
                $display("FAIL countdown cycle %0d: count=%0d done=%0b expected count=%0d done=%0b", n, count1, done1, e.cnt, e.dn);
            end
            step();
        end
        set(1'b0, 1'b0, 1'b0);
        exp_q.push_back({4'd0, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL countdown_idle_done: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        step();
    endtask

    task automatic test_zero_delay();
        exp_t e;
        load(4'd0);
        for (int n = 1; n <= 1000; n++) begin
            set(1'b0, 1'b1, 1'b0);
            exp_q.push_back({4'd0, n == 1000});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({count1, done1} !== {e.cnt, e.dn}) begin
                n_fail++;
                $display("FAIL zero_delay cycle %0d: count=%0d done=%0b expected count=%0d done=%0b", n, count1, done1, e.cnt, e.dn);
            end
            step();
        end
        set(1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_min_param();
        exp_t e;
        load(4'd5);
        for (int n = 1; n <= 6; n++) begin
            set(1'b0, 1'b1, 1'b0);
            exp_q.push_back({4'(5 - (n - 1)), n == 6});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({count2, done2} !== {e.cnt, e.dn}) begin
                n_fail++;
                $display("FAIL min_param cycle %0d: count=%0d done=%0b expected count=%0d done=%0b", n, count2, done2, e.cnt, e.dn);
            end
            step();
        end
        set(1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_simultaneous();
        exp_t e;
        load(4'd1);
        for (int n = 0; n < 5; n++) begin
            set(1'b0, 1'b1, 1'b0);
            step();
        end
        set(1'b1, 1'b1, 1'b0);
        exp_q.push_back({4'd1, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL simul_strobe: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        step();
        // sub must have reloaded: delay 2 holds for a full 1000 cycles
        for (int n = 1; n <= 1001; n++) begin
            set(1'b0, 1'b1, 1'b0);
            exp_q.push_back({(n <= 1000) ? 4'd2 : 4'd1, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({count1, done1} !== {e.cnt, e.dn}) begin
                n_fail++;
                $display("FAIL simul_after cycle %0d: count=%0d done=%0b expected count=%0d done=%0b", n, count1, done1, e.cnt, e.dn);
            end
            step();
        end
        set(1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_pause();
        exp_t e;
        int active = 0;
        load(4'd1);
        for (int w = 1; w <= 2010; w++) begin
            logic cn;
            cn = !(w > 500 && w <= 510);
            set(1'b0, cn, 1'b0);
            if (cn) active++;
            exp_q.push_back({(active <= 1000) ? 4'd1 : 4'd0, cn && active == 2000});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({count1, done1} !== {e.cnt, e.dn}) begin
                n_fail++;
                $display("FAIL pause wall cycle %0d: count=%0d done=%0b expected count=%0d done=%0b", w, count1, done1, e.cnt, e.dn);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int n = 1; n <= 50; n++) begin
            set(1'b0, 1'b1, 1'b0);
            exp_q.push_back({4'd0, 1'b1});
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({count1, done1} !== {e.cnt, e.dn}) begin
                n_fail++;
                $display("FAIL saturation cycle %0d: count=%0d done=%0b expected count=%0d done=%0b", n, count1, done1, e.cnt, e.dn);
            end
            step();
        end
        set(1'b0, 1'b0, 1'b0);
        exp_q.push_back({4'd0, 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({count1, done1} !== {e.cnt, e.dn}) begin
            n_fail++;
            $display("FAIL saturation_idle: count=%0d done=%0b expected count=%0d done=%0b", count1, done1, e.cnt, e.dn);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_shift();
        test_countdown();
        test_zero_delay();
        test_min_param();
        test_simultaneous();
        test_pause();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
